// File: rtl/latch_write_ctrl.sv
// Purpose: arbitrates two writers and a clear onto a latch bank, sequencing setup/gate/hold timing.
// Latency: grant on the IDLE edge; ack pulses SETUP+PULSE+HOLD+1 edges later (outputs lag state by one edge).
// Backpressure: requesters hold req until ack; requests outside IDLE are ignored, never abort a sequence.
//
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   req0/data0          - requester 0 write request and data
//   req1/data1          - requester 1 write request and data
//   clr_req             - bank clear request (highest priority)
//   lat_d/lat_g/lat_clr - registered latch bank data, gate and clear
//   ack0/ack1/clr_done  - one-cycle completion pulses
//   busy/grant_id       - sequence in progress and current owner
module latch_write_ctrl #(
    parameter int WIDTH = 8,
    parameter int SETUP = 1,
    parameter int PULSE = 2,
    parameter int HOLD  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] data0,
    input  logic             req1,
    input  logic [WIDTH-1:0] data1,
    input  logic             clr_req,
    output logic [WIDTH-1:0] lat_d,
    output logic             lat_g,
    output logic             lat_clr,
    output logic             ack0,
    output logic             ack1,
    output logic             clr_done,
    output logic             busy,
    output logic             grant_id
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_GATE  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DONE  = 3'd4,
        ST_CLEAR = 3'd5
    } state_t;

    localparam logic [3:0] SETUP_LD = 4'(SETUP - 1);
    localparam logic [3:0] PULSE_LD = 4'(PULSE - 1);
    localparam logic [3:0] HOLD_LD  = 4'(HOLD - 1);

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] lat_d_q, lat_d_d;
    logic             lat_g_q, lat_g_d;
    logic             lat_clr_q, lat_clr_d;
    logic             ack0_q, ack0_d;
    logic             ack1_q, ack1_d;
    logic             clr_done_q, clr_done_d;
    logic             busy_q, busy_d;
    logic             grant_id_q, grant_id_d;
    // Requester that wins a tie in IDLE; flips to the other one after every grant.
    logic             prio_q, prio_d;
    // DONE is shared by writes and clears; this remembers which one got us there.
    logic             is_clr_q, is_clr_d;
    logic             sel;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        lat_d_d    = lat_d_q;
        grant_id_d = grant_id_q;
        prio_d     = prio_q;
        is_clr_d   = is_clr_q;
        sel        = 1'b0;

        // Output flops decode the current state, so every output lags the state by one edge
        // and gate/clear are mutually exclusive by construction.
        lat_g_d    = (state_q == ST_GATE);
        lat_clr_d  = (state_q == ST_CLEAR);
        busy_d     = (state_q != ST_IDLE);
        ack0_d     = (state_q == ST_DONE) && !is_clr_q && !grant_id_q;
        ack1_d     = (state_q == ST_DONE) && !is_clr_q &&  grant_id_q;
        clr_done_d = (state_q == ST_DONE) &&  is_clr_q;

        case (state_q)
            ST_IDLE: begin
                if (clr_req) begin
                    state_d  = ST_CLEAR;
                    cnt_d    = PULSE_LD;
                    is_clr_d = 1'b1;
                end else if (req0 || req1) begin
                    sel        = (req0 && req1) ? prio_q : req1;
                    grant_id_d = sel;
                    lat_d_d    = sel ? data1 : data0;
                    prio_d     = ~sel;
                    cnt_d      = SETUP_LD;
                    is_clr_d   = 1'b0;
                    state_d    = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_GATE;
                    cnt_d   = PULSE_LD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_GATE: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_LD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_HOLD: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_CLEAR: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            lat_d_q    <= '0;
            lat_g_q    <= 1'b0;
            lat_clr_q  <= 1'b0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            clr_done_q <= 1'b0;
            busy_q     <= 1'b0;
            grant_id_q <= 1'b0;
            prio_q     <= 1'b0;
            is_clr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            lat_d_q    <= lat_d_d;
            lat_g_q    <= lat_g_d;
            lat_clr_q  <= lat_clr_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
            clr_done_q <= clr_done_d;
            busy_q     <= busy_d;
            grant_id_q <= grant_id_d;
            prio_q     <= prio_d;
            is_clr_q   <= is_clr_d;
        end
    end

    assign lat_d    = lat_d_q;
    assign lat_g    = lat_g_q;
    assign lat_clr  = lat_clr_q;
    assign ack0     = ack0_q;
    assign ack1     = ack1_q;
    assign clr_done = clr_done_q;
    assign busy     = busy_q;
    assign grant_id = grant_id_q;

endmodule

// File: tb/tb_latch_write_ctrl.sv
// Purpose: directed bench for latch_write_ctrl (default timing plus a SETUP=3/PULSE=1/HOLD=2 instance).
// Latency: checks are taken 1 ns after each rising edge.
// Backpressure: requests are held until the expected ack, then dropped or kept as each step needs.
module tb_latch_write_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1, clr_req;
    logic [7:0] data0, data1;
    logic [7:0] lat_d;
    logic       lat_g, lat_clr, ack0, ack1, clr_done, busy, grant_id;

    logic       rst_b, req0_b, req1_b, clr_req_b;
    logic [7:0] data0_b, data1_b;
    logic [7:0] lat_d_b;
    logic       lat_g_b, lat_clr_b, ack0_b, ack1_b, clr_done_b, busy_b, grant_id_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    latch_write_ctrl #(.WIDTH(8), .SETUP(1), .PULSE(2), .HOLD(1)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .data0(data0), .req1(req1), .data1(data1), .clr_req(clr_req),
        .lat_d(lat_d), .lat_g(lat_g), .lat_clr(lat_clr),
        .ack0(ack0), .ack1(ack1), .clr_done(clr_done), .busy(busy), .grant_id(grant_id)
    );

    latch_write_ctrl #(.WIDTH(8), .SETUP(3), .PULSE(1), .HOLD(2)) dut_b (
        .clk(clk), .rst(rst_b),
        .req0(req0_b), .data0(data0_b), .req1(req1_b), .data1(data1_b), .clr_req(clr_req_b),
        .lat_d(lat_d_b), .lat_g(lat_g_b), .lat_clr(lat_clr_b),
        .ack0(ack0_b), .ack1(ack1_b), .clr_done(clr_done_b), .busy(busy_b), .grant_id(grant_id_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Next rising edge is the grant edge k; walks to k+5 where ack is expected.
    // With late=1, req1 is raised while the gate is open.
    task automatic do_write(input string tag, input logic id, input logic [7:0] d, input logic late);
        tick(); // k
        chk({tag, "_lat_d"}, lat_d, d);
        chk({tag, "_grant"}, grant_id, id);
        chk({tag, "_busy_k"}, busy, 0);
        tick(); // k+1
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_g_k1"}, lat_g, 0);
        tick(); // k+2
        chk({tag, "_g_k2"}, lat_g, 1);
        chk({tag, "_nooverlap"}, lat_clr, 0);
        if (late) req1 = 1'b1;
        tick(); // k+3
        chk({tag, "_g_k3"}, lat_g, 1);
        tick(); // k+4
        chk({tag, "_g_k4"}, lat_g, 0);
        chk({tag, "_hold_d"}, lat_d, d);
        chk({tag, "_noack"}, {ack1, ack0}, 0);
        tick(); // k+5
        chk({tag, "_ack"}, {ack1, ack0}, id ? 2'b10 : 2'b01);
        chk({tag, "_d_at_ack"}, lat_d, d);
    endtask

    initial begin
        int g_cnt;
        int d_bad;
        rst = 1'b1; req0 = 0; req1 = 0; clr_req = 0; data0 = 8'h00; data1 = 8'h00;
        rst_b = 1'b1; req0_b = 0; req1_b = 0; clr_req_b = 0; data0_b = 8'h00; data1_b = 8'h00;

        // Reset state, with requests asserted to show reset wins.
        req0 = 1; req1 = 1; clr_req = 1;
        tick(); tick();
        chk("rst_outs", {lat_d, lat_g, lat_clr, ack0, ack1, clr_done, busy, grant_id}, 0);
        req0 = 0; req1 = 0; clr_req = 0;
        rst = 0; rst_b = 0;
        tick();
        chk("idle_busy", busy, 0);

        // Single write with defaults.
        req0 = 1; data0 = 8'hA5;
        do_write("single", 1'b0, 8'hA5, 1'b0);
        req0 = 0;
        tick(); // k+6
        chk("single_busy_lo", busy, 0);
        chk("single_ack_lo", ack0, 0);
        tick();

        // Contention from reset: 0, then 1, then 0.
        rst = 1; tick(); rst = 0;
        req0 = 1; req1 = 1; data0 = 8'h11; data1 = 8'h22;
        do_write("cont0", 1'b0, 8'h11, 1'b0);
        do_write("cont1", 1'b1, 8'h22, 1'b0);
        do_write("cont2", 1'b0, 8'h11, 1'b0);
        req0 = 0; req1 = 0;
        tick(); tick();

        // Clear priority over both writers.
        rst = 1; tick(); rst = 0;
        clr_req = 1; req0 = 1; req1 = 1; data0 = 8'h33; data1 = 8'h44;
        tick(); // k
        chk("clr_k", {lat_clr, lat_g}, 0);
        tick(); // k+1
        chk("clr_k1", {lat_clr, lat_g}, 2'b10);
        chk("clr_keep_d", lat_d, 8'h00);
        tick(); // k+2
        chk("clr_k2", {lat_clr, lat_g}, 2'b10);
        chk("clr_nodone", clr_done, 0);
        tick(); // k+3
        chk("clr_done", clr_done, 1);
        chk("clr_off", lat_clr, 0);
        chk("clr_noack", {ack1, ack0}, 0);
        clr_req = 0;
        do_write("clr_w0", 1'b0, 8'h33, 1'b0);
        req0 = 0;
        do_write("clr_w1", 1'b1, 8'h44, 1'b0);
        req1 = 0;
        tick(); tick();

        // Late request: req1 rises during requester 0's gate.
        rst = 1; tick(); rst = 0;
        req0 = 1; data0 = 8'h5A; data1 = 8'hC3;
        do_write("late0", 1'b0, 8'h5A, 1'b1);
        req0 = 0;
        do_write("late1", 1'b1, 8'hC3, 1'b0);
        req1 = 0;
        tick(); tick();

        // Reset while the gate is open.
        req0 = 1; data0 = 8'h77;
        tick(); tick(); tick(); // k, k+1, k+2
        chk("mid_gate_open", lat_g, 1);
        rst = 1;
        tick();
        chk("mid_rst_g", lat_g, 0);
        chk("mid_rst_busy", busy, 0);
        rst = 0; req0 = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("mid_rst_noack", {ack1, ack0, busy}, 0);
        end
        req0 = 1; req1 = 1; data0 = 8'h01; data1 = 8'h02;
        do_write("post_rst", 1'b0, 8'h01, 1'b0);
        req0 = 0; req1 = 0;
        tick(); tick();

        // Parameter sweep instance: SETUP=3, PULSE=1, HOLD=2.
        req1_b = 1; data1_b = 8'h9C;
        tick(); // k
        req1_b = 0; // dropped early, sequence must still complete
        chk("sw_lat_d", lat_d_b, 8'h9C);
        chk("sw_grant", grant_id_b, 1);
        g_cnt = 0;
        d_bad = 0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (lat_g_b) g_cnt++;
            if (lat_d_b !== 8'h9C) d_bad++;
            chk("sw_noack", ack1_b, 0);
        end
        chk("sw_gate_len", g_cnt, 1);
        chk("sw_d_stable", d_bad, 0);
        tick(); // k+7
        chk("sw_ack", {ack1_b, ack0_b}, 2'b10);
        tick();
        chk("sw_ack_pulse", ack1_b, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
